arch_cdc_capture: RTL

Destination-side capture stage for a multi-bit word that arrives through a per-bit synchroniser array. It qualifies the bit-skewed synchronised bus in the `dst_clk` domain. A new value is accepted only after it has held unchanged for `STABLE_CYCLES` clocks. Each accepted word is presented once on a valid/ready output with a one-deep overwrite buffer. It sits directly after the synchroniser array on the reading side of every multi-bit status/config crossing.

---
 rtl/arch_cdc_capture_pkg.sv | 6 +
 rtl/arch_cdc_capture_if.sv | 8 +
 rtl/arch_cdc_stable_filter.sv | 41 ++++
 rtl/arch_cdc_capture.sv | 60 ++++++
 4 files changed

// File: rtl/arch_cdc_capture_pkg.sv
// arch_cdc_pkg: shared types and widths for the CDC capture stage
package arch_cdc_pkg;
  typedef enum logic {IDLE, SETTLE} cdc_cap_state_t;
  localparam int CDC_CAP_CNT_W = 8;
  localparam int CDC_CAP_DROP_W = 16;
endpackage

// File: rtl/arch_cdc_capture_if.sv
// arch_cdc_capture_if: valid/ready word channel out of the capture stage
interface arch_cdc_capture_if #(parameter int WIDTH = 2);
  logic m_tvalid;
  logic m_tready;
  logic [WIDTH-1:0] m_tdata;
  modport master(output m_tvalid, m_tdata, input m_tready);
  modport slave(input m_tvalid, m_tdata, output m_tready);
endinterface

// File: rtl/arch_cdc_stable_filter.sv
// arch_cdc_stable_filter: holds a bit-skewed bus until stable, strobes commit on new words
module arch_cdc_stable_filter
  import arch_cdc_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int STABLE_CYCLES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             dst_clk,
  input  logic             dst_rst,
  input  logic [WIDTH-1:0] sync_data,
  input  logic [WIDTH-1:0] committed,
  output logic [WIDTH-1:0] s_q,
  output logic             commit,
  output logic             busy
);
  localparam logic [CDC_CAP_CNT_W-1:0] LIM = CDC_CAP_CNT_W'(STABLE_CYCLES - 1);
  cdc_cap_state_t state;
  logic [CDC_CAP_CNT_W-1:0] cnt;
  logic diff;
  assign diff = sync_data != s_q;
  assign busy = state == SETTLE;
  // window closes on the cycle the count has already reached its limit
  assign commit = busy && !diff && cnt >= LIM && s_q != committed;
  always_ff @(posedge dst_clk or posedge dst_rst) begin
    if (dst_rst) begin
      s_q <= RESET_VALUE;
      cnt <= '0;
      state <= IDLE;
    end else begin
      s_q <= sync_data;
      if (diff) begin
        cnt <= '0;
        state <= SETTLE;
      end else if (busy) begin
        if (cnt < LIM) cnt <= cnt + 1'b1;
        else state <= IDLE;
      end
    end
  end
endmodule

// File: rtl/arch_cdc_capture.sv
// arch_cdc_capture: qualified capture of a synchronised word onto a one-deep overwrite buffer
// ARCH_CDC_CAPTURE_DROP_COUNT_EN enables the saturating drop counter
module arch_cdc_capture
  import arch_cdc_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int STABLE_CYCLES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                      dst_clk,
  input  logic                      dst_rst,
  input  logic [WIDTH-1:0]          sync_data,
  arch_cdc_capture_if.master        m,
  output logic                      drop,
  output logic                      busy,
  output logic [CDC_CAP_DROP_W-1:0] drop_count
);
  logic [WIDTH-1:0] s_q, committed, data_q;
  logic commit, valid_q, busy_w, drop_n;
  arch_cdc_stable_filter #(.WIDTH(WIDTH), .STABLE_CYCLES(STABLE_CYCLES), .RESET_VALUE(RESET_VALUE)) u_filter (
    .dst_clk(dst_clk),
    .dst_rst(dst_rst),
    .sync_data(sync_data),
    .committed(committed),
    .s_q(s_q),
    .commit(commit),
    .busy(busy_w)
  );
  assign busy = busy_w;
  assign drop_n = commit && valid_q && !m.m_tready;
  assign m.m_tvalid = valid_q;
  assign m.m_tdata = data_q;
  always_ff @(posedge dst_clk or posedge dst_rst) begin
    if (dst_rst) begin
      committed <= RESET_VALUE;
      data_q <= RESET_VALUE;
      valid_q <= 1'b0;
      drop <= 1'b0;
    end else begin
      drop <= drop_n;
      if (commit) begin
        committed <= s_q;
        data_q <= s_q;
        valid_q <= 1'b1;
      end else if (valid_q && m.m_tready) begin
        valid_q <= 1'b0;
      end
    end
  end
`ifdef ARCH_CDC_CAPTURE_DROP_COUNT_EN
  logic [CDC_CAP_DROP_W-1:0] dc_q;
  always_ff @(posedge dst_clk or posedge dst_rst) begin
    if (dst_rst) dc_q <= '0;
    else if (drop_n && dc_q != '1) dc_q <= dc_q + 1'b1;
  end
  assign drop_count = dc_q;
`else
  assign drop_count = '0;
`endif
endmodule
